metaframe_ctrl: RTL and testbench
=================================

# metaframe_ctrl

Per-lane Interlaken metaframe sequencer that feeds the 64B/67B encoder. It interleaves user payload words with the framing-layer control words: Sync, Scrambler State, Skip and Diagnostic. It also inserts Idle words when upstream has no data, and holds the stream during gearbox pause cycles. It sits between the lane payload source and `encode_64B_67B`, driving the encoder's `DATA_IN`/`HEADER_IN` directly.

## Interface
- `MF_LEN`, default 2048: metaframe length in words, including 4 control words; legal range 8..65535.
- `USER_CLK`  in  1: lane clock, all logic on rising edge.
- `SYSTEM_RESET_N`  in  1: asynchronous, active-low reset.
- `S_DATA`  in  64: payload word from upstream.
- `S_VALID`  in  1: `S_DATA` valid.
- `S_READY`  out  1: controller accepts `S_DATA` this cycle.
- `TX_PAUSE`  in  1: gearbox pause; the sequence freezes for this cycle.
- `SCRAM_STATE`  in  58: current scrambler state, sampled for the Scrambler State word.
- `LANE_STATUS`  in  2: {lane_ok, link_ok}, placed in the Diagnostic word.
- `DATA_OUT`  out  64: word to encoder `DATA_IN`.
- `HEADER_OUT`  out  2: to encoder `HEADER_IN`; 2'b01 = data, 2'b10 = control.
- `WORD_VALID`  out  1: `DATA_OUT`/`HEADER_OUT` carry a new word.
- `MF_START`  out  1: one-cycle pulse coincident with the Sync word on `DATA_OUT`.

## Operation
- **FSM states:** SYNC → SCRAM → SKIP → DATA → DIAG → SYNC.
  - SYNC, SCRAM, SKIP and DIAG each last exactly one unpaused cycle.
  - DATA lasts MF_LEN−4 unpaused cycles.
- **Word counter:** 16 bits, 0..MF_LEN−1; advances only on cycles with `TX_PAUSE`=0 and wraps to 0 at DIAG.
- **Words emitted**, all registered:
  - SYNC: header 10, payload 64'h78F6_78F6_78F6_78F6; `MF_START`=1.
  - SCRAM: header 10, payload {6'b001010, `SCRAM_STATE`} sampled the same cycle.
  - SKIP: header 10, payload SKIP_WORD constant 64'h1E00_0000_0000_0000.
  - DATA with an accepted beat: header 01, payload `S_DATA`.
  - DATA with no accepted beat: header 10, payload IDLE_WORD 64'h1E00_0000_0000_0001. The data slot is consumed either way.
  - DIAG: header 10, payload {6'b011001, 24'h0, `LANE_STATUS`, CRC field[31:0]}.
- **Handshake:**
  - `S_READY` = (state==DATA) && !`TX_PAUSE`, combinational.
  - A transfer occurs when `S_VALID` && `S_READY`.
  - `S_DATA` may change freely while `S_READY`=0.
- **`TX_PAUSE`=1:**
  - FSM, counter and CRC hold.
  - `WORD_VALID`=0.
  - `DATA_OUT`/`HEADER_OUT` hold their previous values.
  - No transfer occurs.
- **Reset:** asserting `SYSTEM_RESET_N` low at any point, including mid-metaframe, returns FSM to SYNC and counter to 0 immediately.
  - All outputs read 0 during reset.
  - A partial metaframe is abandoned with no Diagnostic word.

## Timing
- Registered outputs: a word accepted at edge N appears on `DATA_OUT` after edge N, i.e. one-cycle latency. Control words follow the same latency.
- First unpaused edge after reset deassertion: `DATA_OUT` = Sync, `MF_START`=1, `WORD_VALID`=1.
- Metaframe period is MF_LEN unpaused cycles: Sync words are exactly MF_LEN `WORD_VALID` beats apart.
- `TX_PAUSE` on the cycle the FSM would leave DIAG delays the Sync by one cycle. No word is dropped or repeated.
- `S_VALID` rising on the last DATA cycle is accepted. On the following DIAG/SYNC/SCRAM/SKIP cycles `S_READY`=0 and upstream holds.

## Configuration
- `METAFRAME_CRC32_EN` defined:
  - A CRC-32C is computed over every word of the metaframe, Sync through Diagnostic. Polynomial 0x1EDC6F41, init 32'hFFFF_FFFF, result inverted.
  - The Diagnostic word's CRC field is treated as zero during the calculation.
  - The result is written to `DATA_OUT`[31:0] of the DIAG word.
  - CRC reinitialises at each Sync.
- Not defined: CRC field is 32'h0 and no CRC logic is synthesised. All other behaviour is identical.

## Structure
- Shared package `interlaken_pkg` holds:
  - SYNC_WORD, SKIP_WORD, IDLE_WORD;
  - block-type codes SCRAM_TYPE=6'b001010 and DIAG_TYPE=6'b011001;
  - header codes HDR_DATA=2'b01 and HDR_CTRL=2'b10;
  - the FSM state enum.
- One sub-module: `crc32c_64`, a combinational 64-bit-per-cycle CRC-32C update (crc_in, data_in → crc_out). It is instantiated only under `METAFRAME_CRC32_EN`.

## Test plan
- **Reset release, MF_LEN=8, `S_VALID`=0:**
  - Stream is Sync (`MF_START`=1), SCRAM with `SCRAM_STATE`, SKIP, then 4 × IDLE (header 10), then DIAG, then Sync again on beat 9.
- **`S_VALID`=1 continuous, `S_DATA`=1,2,3…, MF_LEN=8:**
  - Data slots carry 1,2,3,4 with header 01.
  - `S_READY` is low for 4 cycles around DIAG/SYNC/SCRAM/SKIP.
  - Next metaframe carries 5..8; no word is lost.
- **`TX_PAUSE` asserted one cycle in mid-DATA with `S_VALID`=1:**
  - `S_READY`=0 and `WORD_VALID`=0 that cycle; output holds.
  - Payload resumes with the same word; Sync spacing becomes 9 cycles, still 8 valid beats.
- **Reset asserted at word 5 of a metaframe:**
  - Outputs go to 0 asynchronously.
  - After release the first word is Sync; there is no DIAG for the aborted frame.
- **`METAFRAME_CRC32_EN` defined, MF_LEN=8, data 64'h0:**
  - DIAG[31:0] equals the reference-model CRC-32C of the 8-word frame with the CRC field zeroed.
  - `LANE_STATUS`=2'b11 appears in DIAG[33:32].
- **Macro undefined, same stimulus:** DIAG[31:0]=32'h0; all other words bit-identical to the CRC build.

Source files
------------

// File: rtl/interlaken_pkg.sv
// Shared Interlaken framing-layer constants and the metaframe FSM state type.
package interlaken_pkg;

  // Framing-layer control word payloads
  localparam logic [63:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] SKIP_WORD = 64'h1E00_0000_0000_0000;
  localparam logic [63:0] IDLE_WORD = 64'h1E00_0000_0000_0001;

  // Block-type codes in the top six bits of the Scrambler State and Diagnostic words
  localparam logic [5:0] SCRAM_TYPE = 6'b001010;
  localparam logic [5:0] DIAG_TYPE  = 6'b011001;

  // 64B/67B header codes
  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // CRC-32C (Castagnoli) parameters for the Diagnostic word
  localparam logic [31:0] CRC_POLY = 32'h1EDC_6F41;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Metaframe sequencer states, in emission order
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_SCRAM,
    ST_SKIP,
    ST_DATA,
    ST_DIAG
  } mf_state_t;

endpackage

// File: rtl/crc32c_64.sv
// Combinational CRC-32C update over one 64-bit word, MSB first, non-reflected.
module crc32c_64
  import interlaken_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data_in,
  output logic [31:0] crc_out
);

  // Unrolled bit-serial LFSR: data_in[63] enters first
  always_comb begin
    logic [31:0] c;
    logic        fb;
    c  = crc_in;
    fb = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      fb = c[31] ^ data_in[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ CRC_POLY;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/metaframe_ctrl.sv
// Per-lane Interlaken metaframe sequencer feeding the 64B/67B encoder.
// Optional feature: define METAFRAME_CRC32_EN to fill the Diagnostic word's
// CRC field with a CRC-32C over the whole metaframe; otherwise the field is zero.
module metaframe_ctrl
  import interlaken_pkg::*;
#(
  parameter int MF_LEN = 2048
)
(
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic [63:0] S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic        TX_PAUSE,
  input  logic [57:0] SCRAM_STATE,
  input  logic [1:0]  LANE_STATUS,
  output logic [63:0] DATA_OUT,
  output logic [1:0]  HEADER_OUT,
  output logic        WORD_VALID,
  output logic        MF_START
);

  // Counter value on the last data slot; DIAG follows it
  localparam logic [15:0] DATA_LAST = 16'(MF_LEN - 2);

  mf_state_t   state;
  mf_state_t   state_next;
  logic [15:0] count;
  logic [15:0] count_next;
  logic [63:0] word_base;
  logic [63:0] word_next;
  logic [1:0]  hdr_next;
  logic [31:0] crc_field;

  assign S_READY = (state == ST_DATA) && !TX_PAUSE;

  // Select the word for the current slot (CRC field left zero) and the next slot
  always_comb begin
    state_next = state;
    count_next = count + 16'd1;
    word_base  = '0;
    hdr_next   = HDR_CTRL;
    case (state)
      ST_SYNC: begin
        word_base  = SYNC_WORD;
        state_next = ST_SCRAM;
      end
      ST_SCRAM: begin
        word_base  = {SCRAM_TYPE, SCRAM_STATE};
        state_next = ST_SKIP;
      end
      ST_SKIP: begin
        word_base  = SKIP_WORD;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        if (S_VALID) begin
          word_base = S_DATA;
          hdr_next  = HDR_DATA;
        end else begin
          word_base = IDLE_WORD;
        end
        if (count == DATA_LAST) begin
          state_next = ST_DIAG;
        end
      end
      ST_DIAG: begin
        word_base  = {DIAG_TYPE, 24'h0, LANE_STATUS, 32'h0};
        state_next = ST_SYNC;
        count_next = '0;
      end
      default: begin
        state_next = ST_SYNC;
        count_next = '0;
      end
    endcase
  end

`ifdef METAFRAME_CRC32_EN
  logic [31:0] crc_reg;
  logic [31:0] crc_seed;
  logic [31:0] crc_out;

  assign crc_seed  = (state == ST_SYNC) ? CRC_INIT : crc_reg;
  assign crc_field = (state == ST_DIAG) ? ~crc_out : 32'h0;

  crc32c_64 u_crc (
    .crc_in  (crc_seed),
    .data_in (word_base),
    .crc_out (crc_out)
  );

  // Running CRC across the metaframe; restarts from the seed at each Sync
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      crc_reg <= CRC_INIT;
    end else if (!TX_PAUSE) begin
      crc_reg <= crc_out;
    end
  end
`else
  assign crc_field = 32'h0;
`endif

  assign word_next = word_base | {32'h0, crc_field};

  // Sequencer state, slot counter and registered encoder-facing outputs
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state      <= ST_SYNC;
      count      <= '0;
      DATA_OUT   <= '0;
      HEADER_OUT <= '0;
      WORD_VALID <= 1'b0;
      MF_START   <= 1'b0;
    end else if (TX_PAUSE) begin
      WORD_VALID <= 1'b0;
      MF_START   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      DATA_OUT   <= word_next;
      HEADER_OUT <= hdr_next;
      WORD_VALID <= 1'b1;
      MF_START   <= (state == ST_SYNC);
    end
  end

endmodule

// File: tb/tb_metaframe_ctrl.sv
// Self-checking bench for metaframe_ctrl with a slot-position reference model.
module tb_metaframe_ctrl;

  localparam int          MF_LEN = 8;
  localparam logic [31:0] POLY   = 32'h1EDC_6F41;

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET_N = 1'b0;
  logic [63:0] S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic        TX_PAUSE = 1'b0;
  logic [57:0] SCRAM_STATE = '0;
  logic [1:0]  LANE_STATUS = '0;
  logic [63:0] DATA_OUT;
  logic [1:0]  HEADER_OUT;
  logic        WORD_VALID;
  logic        MF_START;

  int errors = 0;
  int checks = 0;

  // Reference model: position of the next word inside the metaframe
  int          pos = 0;
  logic [63:0] exp_data = '0;
  logic [1:0]  exp_hdr = '0;
  logic        exp_valid = 1'b0;
  logic        exp_start = 1'b0;
  logic [63:0] frame_words [MF_LEN];
  logic [63:0] src_seq = 64'd1;
  bit          zero_data = 1'b0;
  bit          lane_ok_all = 1'b0;

  metaframe_ctrl #(.MF_LEN(MF_LEN)) dut (
    .USER_CLK       (USER_CLK),
    .SYSTEM_RESET_N (SYSTEM_RESET_N),
    .S_DATA         (S_DATA),
    .S_VALID        (S_VALID),
    .S_READY        (S_READY),
    .TX_PAUSE       (TX_PAUSE),
    .SCRAM_STATE    (SCRAM_STATE),
    .LANE_STATUS    (LANE_STATUS),
    .DATA_OUT       (DATA_OUT),
    .HEADER_OUT     (HEADER_OUT),
    .WORD_VALID     (WORD_VALID),
    .MF_START       (MF_START)
  );

  always #5 USER_CLK = ~USER_CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // CRC-32C of the whole recorded frame treated as one MSB-first bit stream
  function automatic logic [31:0] refCrc();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int w = 0; w < MF_LEN; w++) begin
      for (int b = 63; b >= 0; b--) begin
        fb = c[31] ^ frame_words[w][b];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return ~c;
  endfunction

  task automatic checkAllOutputs(input string phase);
    checkOutput({phase, "_data"},  DATA_OUT,   exp_data);
    checkOutput({phase, "_hdr"},   {62'h0, HEADER_OUT}, {62'h0, exp_hdr});
    checkOutput({phase, "_valid"}, {63'h0, WORD_VALID}, {63'h0, exp_valid});
    checkOutput({phase, "_start"}, {63'h0, MF_START},   {63'h0, exp_start});
  endtask

  // One clock cycle of stimulus, model update and output comparison
  task automatic applyStimulus(input bit pause, input bit valid);
    logic [63:0] rnd;
    logic [63:0] w;
    logic [1:0]  h;
    bit          in_data;
    bit          exp_ready;
    rnd = {$urandom, $urandom};
    TX_PAUSE = pause;
    S_VALID  = valid;
    if (valid) S_DATA = zero_data ? 64'h0 : src_seq;
    else       S_DATA = {$urandom, $urandom};
    SCRAM_STATE = rnd[57:0];
    LANE_STATUS = lane_ok_all ? 2'b11 : 2'($urandom_range(0, 3));
    #1;
    in_data   = (pos >= 3) && (pos <= MF_LEN - 2);
    exp_ready = in_data && !pause;
    checkOutput("s_ready", {63'h0, S_READY}, {63'h0, exp_ready});
    if (!pause) begin
      h = 2'b10;
      if (pos == 0)               w = 64'h78F6_78F6_78F6_78F6;
      else if (pos == 1)          w = {6'b001010, SCRAM_STATE};
      else if (pos == 2)          w = 64'h1E00_0000_0000_0000;
      else if (pos == MF_LEN - 1) w = {6'b011001, 24'h0, LANE_STATUS, 32'h0};
      else if (valid) begin
        w = S_DATA;
        h = 2'b01;
      end else                    w = 64'h1E00_0000_0000_0001;
      frame_words[pos] = w;
`ifdef METAFRAME_CRC32_EN
      if (pos == MF_LEN - 1) w[31:0] = refCrc();
`endif
      exp_start = (pos == 0);
      exp_valid = 1'b1;
      exp_data  = w;
      exp_hdr   = h;
      pos       = (pos + 1) % MF_LEN;
      if (valid && in_data) src_seq++;
    end else begin
      exp_start = 1'b0;
      exp_valid = 1'b0;
    end
    @(posedge USER_CLK);
    #1;
    checkAllOutputs("cyc");
  endtask

  // Advance unpaused until the model's next slot equals target (bounded)
  task automatic runTo(input int target, input bit valid);
    for (int i = 0; i < MF_LEN + 1; i++) begin
      if (pos == target) break;
      applyStimulus(1'b0, valid);
    end
    checkOutput("run_to_pos", 64'(pos), 64'(target));
  endtask

  task automatic resetModel();
    pos       = 0;
    exp_data  = '0;
    exp_hdr   = '0;
    exp_valid = 1'b0;
    exp_start = 1'b0;
  endtask

  initial begin
    // Power-on reset: all outputs zero while held
    #12;
    checkAllOutputs("rst");
    checkOutput("rst_ready", {63'h0, S_READY}, 64'h0);
    #1 SYSTEM_RESET_N = 1'b1;
    resetModel();

    // Idle frames: Sync, Scram, Skip, idles, Diag, Sync again
    for (int i = 0; i < 2 * MF_LEN + 1; i++) applyStimulus(1'b0, 1'b0);

    // Continuous valid data across two frames
    for (int i = 0; i < 2 * MF_LEN; i++) applyStimulus(1'b0, 1'b1);

    // Single pause in the middle of the data slots
    runTo(4, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < MF_LEN; i++) applyStimulus(1'b0, 1'b1);

    // Pause on the cycle the sequencer leaves Diag
    runTo(MF_LEN - 1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < MF_LEN; i++) applyStimulus(1'b0, 1'b0);

    // Zero payload, all-ok lane status: Diag CRC field against the model
    zero_data   = 1'b1;
    lane_ok_all = 1'b1;
    runTo(0, 1'b1);
    for (int i = 0; i < 2 * MF_LEN; i++) applyStimulus(1'b0, 1'b1);
    zero_data   = 1'b0;
    lane_ok_all = 1'b0;

    // Randomized pause/valid traffic
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6));

    // Reset in the middle of a frame, outputs clear asynchronously
    runTo(5, 1'b1);
    TX_PAUSE = 1'b0;
    S_VALID  = 1'b1;
    SYSTEM_RESET_N = 1'b0;
    #1;
    resetModel();
    checkAllOutputs("midrst");
    checkOutput("midrst_ready", {63'h0, S_READY}, 64'h0);
    @(posedge USER_CLK);
    #1;
    checkAllOutputs("midrst_hold");
    SYSTEM_RESET_N = 1'b1;
    for (int i = 0; i < 2 * MF_LEN + 2; i++) applyStimulus(1'b0, ($urandom_range(0, 1) == 1));

    // More randomized traffic after the abort
    for (int i = 0; i < 200; i++)
      applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
